// File: rtl/alu_share_arbiter_if.sv
// Requester, shared-ALU and response buses of alu_share_arbiter.
// slave is the arbiter's view; master is the requesters/ALU side.
interface alu_share_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*OP_W-1:0]   req_op;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic                   alu_start;
  logic [OP_W-1:0]        alu_op;
  logic [DATA_W-1:0]      alu_a;
  logic [DATA_W-1:0]      alu_b;
  logic                   alu_done;
  logic [DATA_W-1:0]      alu_result;
  logic [3:0]             alu_flags;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_result;
  logic [3:0]             rsp_flags;
  logic                   rsp_err;
  logic [NREQ-1:0]        rsp_ack;
  logic                   busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_done, alu_result, alu_flags, rsp_ack,
    output req_ready, alu_start, alu_op, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_flags, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_done, alu_result, alu_flags, rsp_ack,
    input  req_ready, alu_start, alu_op, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_flags, rsp_err, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one multi-cycle ALU among NREQ requesters,
// with result routing back to the requester and a WAIT watchdog.
//
// state    | meaning
// IDLE     | searching for a requester, accept strobe combinational
// ISSUE    | one-cycle alu_start, watchdog cleared
// WAIT     | operands held on ALU, waiting for done or watchdog expiry
// RESP     | response held to the granted requester until its ack
module alu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic n_rst,
  alu_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       last_q, cur_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [CW-1:0]       cnt_q;
  logic [DATA_W-1:0]   result_q;
  logic [3:0]          flags_q;
  logic                err_q;

  logic                gnt_found;
  logic [IW-1:0]       gnt_idx, cand;
  logic                take, fin_ok, fin_tmo, ack_take;

  // Search starts just after the last completed requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    fin_ok   = 1'b0;
    fin_tmo  = 1'b0;
    ack_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          take    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // done has priority over a simultaneous watchdog expiry
        if (bus.alu_done) begin
          fin_ok  = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fin_tmo = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ack[cur_q]) begin
          ack_take = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_q   <= IW'(NREQ - 1);
      cur_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (take) begin
        cur_q <= gnt_idx;
        op_q  <= bus.req_op[int'(gnt_idx) * OP_W +: OP_W];
        a_q   <= bus.req_a[int'(gnt_idx) * DATA_W +: DATA_W];
        b_q   <= bus.req_b[int'(gnt_idx) * DATA_W +: DATA_W];
      end
      if (state_q == ST_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == ST_WAIT && !fin_ok && !fin_tmo) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (fin_ok) begin
        result_q <= bus.alu_result;
        flags_q  <= bus.alu_flags;
        err_q    <= 1'b0;
      end else if (fin_tmo) begin
        result_q <= '0;
        flags_q  <= '0;
        err_q    <= 1'b1;
      end
      if (ack_take) begin
        err_q  <= 1'b0;
        last_q <= cur_q;
      end
    end
  end

  logic drive_alu;
  assign drive_alu = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  assign bus.req_ready  = (state_q == ST_IDLE && gnt_found) ? (ONE << gnt_idx) : '0;
  assign bus.alu_start  = (state_q == ST_ISSUE);
  assign bus.alu_op     = drive_alu ? op_q : '0;
  assign bus.alu_a      = drive_alu ? a_q : '0;
  assign bus.alu_b      = drive_alu ? b_q : '0;
  assign bus.rsp_valid  = (state_q == ST_RESP) ? (ONE << cur_q) : '0;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: random requests, a stub ALU with
// programmable latency, randomized ack delay and stray acks on other bits.
module tb_alu_share_arbiter;
  localparam int NREQ = 4, DATA_W = 32, OP_W = 4, TIMEOUT = 8;

  typedef struct { int id; logic [31:0] res; logic [3:0] flg; logic err; int cyc; } rsp_t;
  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; int cyc; } iss_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();
  alu_share_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  int total = 0, bad = 0, cyc = 0, last_m = NREQ - 1;
  int alu_lat = 1, ack_delay = 0, rsp_age = 0;
  logic [31:0] last_res_m = '0;
  logic [3:0]  op_r [NREQ];
  logic [31:0] a_r [NREQ], b_r [NREQ];
  logic [NREQ-1:0] vld = '0, noise = '0;
  logic mdl_done = 1'b0, stray_done = 1'b0;
  logic [31:0] mdl_res = '0;
  logic [3:0]  mdl_flg = '0;
  rsp_t rsp_q[$];
  iss_t iss_q[$];

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign bus.req_op[i*OP_W +: OP_W]     = op_r[i];
    assign bus.req_a[i*DATA_W +: DATA_W]  = a_r[i];
    assign bus.req_b[i*DATA_W +: DATA_W]  = b_r[i];
  end
  assign bus.req_valid  = vld;
  assign bus.alu_done   = mdl_done | stray_done;
  assign bus.alu_result = stray_done ? 32'hDEAD_BEEF : mdl_res;
  assign bus.alu_flags  = stray_done ? 4'hF : mdl_flg;
  assign bus.rsp_ack    = ((rsp_age >= ack_delay) ? bus.rsp_valid : '0) | (noise & ~bus.rsp_valid);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stub ALU datapath: {N,Z,C,V, result}
  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic v;
    v = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (s[31] != a[31]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; v = (a[31] != b[31]) && (s[31] != a[31]); end
      4'd2: s = {1'b0, a & b};
      4'd3: s = {1'b0, a | b};
      4'd4: s = {1'b0, a ^ b};
      default: s = {1'b0, ~a};
    endcase
    return {s[31], s[31:0] == 32'd0, s[32], v, s[31:0]};
  endfunction

  function automatic int predict(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
    return -1;
  endfunction

  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(posedge clk); #1; noise = NREQ'($urandom_range(0, (1 << NREQ) - 1)); end
  initial forever begin
    @(negedge clk);
    if (bus.rsp_valid != '0) rsp_age++;
    else rsp_age = 0;
  end

  // Stub ALU: check issued operands, answer after alu_lat cycles (0 = never)
  logic [3:0] s_op;
  logic [31:0] s_a, s_b;
  int s_lat;
  iss_t ie;
  initial forever begin
    @(negedge clk);
    if (n_rst && bus.alu_start) begin
      if (iss_q.size() == 0) chk("start_unexpected", 1, 0);
      else begin
        ie = iss_q.pop_front();
        chk("issue_op", bus.alu_op, ie.op);
        chk("issue_a", bus.alu_a, ie.a);
        chk("issue_b", bus.alu_b, ie.b);
        chk("issue_cycle", cyc, ie.cyc);
      end
      s_op = bus.alu_op; s_a = bus.alu_a; s_b = bus.alu_b; s_lat = alu_lat;
      if (s_lat > 0) begin
        repeat (s_lat) @(posedge clk);
        #1;
        {mdl_flg, mdl_res} = alu_ref(s_op, s_a, s_b);
        mdl_done = 1'b1;
        @(posedge clk); #1;
        mdl_done = 1'b0;
      end
    end
  end

  // Response monitor
  logic seen = 1'b0, e0;
  logic [NREQ-1:0] v0;
  logic [31:0] r0;
  logic [3:0] f0;
  rsp_t re;
  initial forever begin
    @(negedge clk);
    if (!n_rst) seen = 1'b0;
    else begin
      if (bus.rsp_valid != '0) begin
        if (!seen) begin
          seen = 1'b1;
          v0 = bus.rsp_valid; r0 = bus.rsp_result; f0 = bus.rsp_flags; e0 = bus.rsp_err;
          if (rsp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
          else begin
            re = rsp_q.pop_front();
            chk("rsp_valid", bus.rsp_valid, 1 << re.id);
            chk("rsp_result", bus.rsp_result, re.res);
            chk("rsp_flags", bus.rsp_flags, re.flg);
            chk("rsp_err", bus.rsp_err, re.err);
            chk("rsp_cycle", cyc, re.cyc);
          end
        end else begin
          chk("hold_valid", bus.rsp_valid, v0);
          chk("hold_result", bus.rsp_result, r0);
          chk("hold_flags", bus.rsp_flags, f0);
          chk("hold_err", bus.rsp_err, e0);
        end
      end else begin
        seen = 1'b0;
        chk("err_outside_resp", bus.rsp_err, 0);
      end
      if (bus.busy) chk("ready_while_busy", bus.req_ready, 0);
      else chk("alu_bus_idle", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_start}, 0);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_start"}, bus.alu_start, 0);
    chk({tag, "_alu_bus"}, {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"}, {bus.rsp_result, bus.rsp_flags, bus.rsp_err}, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_r[i] = 4'($urandom_range(0, 5));
      a_r[i] = $urandom;
      b_r[i] = $urandom;
    end
  endtask

  task automatic push_exp(input int g, input int lat, input int acc, output int rc);
    logic [35:0] r;
    logic err;
    err = (lat == 0) || (lat > TIMEOUT);
    r = alu_ref(op_r[g], a_r[g], b_r[g]);
    iss_q.push_back('{op: op_r[g], a: a_r[g], b: b_r[g], cyc: acc + 1});
    rc = acc + 2 + (err ? TIMEOUT : lat);
    last_res_m = err ? 32'd0 : r[31:0];
    rsp_q.push_back('{id: g, res: last_res_m, flg: err ? 4'h0 : r[35:32], err: err, cyc: rc});
  endtask

  task automatic wait_accept(output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin acc = cyc; ok = 1'b1; return; end
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
  endtask

  // One transaction; rst_after>0 pulses reset that many cycles after accept.
  task automatic do_txn(input logic [NREQ-1:0] mask, input int lat, input int ackd,
                        input int rst_after);
    int g, acc, rc;
    bit ok;
    alu_lat = lat;
    ack_delay = ackd;
    @(posedge clk); #1;
    vld = mask;
    g = predict(mask);
    wait_accept(acc, ok);
    if (!ok) begin vld = '0; return; end
    chk("grant", bus.req_ready, 1 << g);
    if (rst_after > 0)
      iss_q.push_back('{op: op_r[g], a: a_r[g], b: b_r[g], cyc: acc + 1});
    else
      push_exp(g, lat, acc, rc);
    @(posedge clk); #1;
    vld = '0;
    if (rst_after > 0) begin
      repeat (rst_after - 1) @(posedge clk);
      #1;
      n_rst = 1'b0;
      #1;
      chk_zero("midop_reset");
      @(negedge clk); @(negedge clk);
      n_rst = 1'b1;
      last_m = NREQ - 1;
      last_res_m = '0;
      return;
    end
    wait_idle();
    chk("idle_cycle", cyc, rc + ((ackd < 1) ? 1 : ackd));
    last_m = g;
  endtask

  task automatic rr_held();
    int acc, prev, g, rc;
    bit ok;
    alu_lat = 1;
    ack_delay = 0;
    prev = 0;
    rand_ops();
    @(posedge clk); #1;
    vld = '1;
    for (int t = 0; t < 5; t++) begin
      g = predict(vld);
      wait_accept(acc, ok);
      if (!ok) break;
      chk("rr_grant", bus.req_ready, 1 << g);
      push_exp(g, 1, acc, rc);
      if (t > 0) chk("rr_spacing", acc - prev, 4);
      prev = acc;
      last_m = g;
    end
    @(posedge clk); #1;
    vld = '0;
    wait_idle();
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int sel, lat;
    rand_ops();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    n_rst = 1'b1;

    // single ADD 5+7, latency 3
    op_r[0] = 4'd0; a_r[0] = 32'd5; b_r[0] = 32'd7;
    do_txn(4'b0001, 3, 0, 0);

    do_txn(4'b1000, 2, 0, 0);
    rr_held();

    // requester 2 served, then 0 and 2 pending: 0 wins
    rand_ops();
    do_txn(4'b0100, 1, 0, 0);
    do_txn(4'b0101, 2, 1, 0);

    // watchdog abort, done on terminal count, late done landing in RESP
    rand_ops();
    do_txn(4'b0010, 0, 0, 0);
    do_txn(4'b0010, TIMEOUT, 0, 0);
    do_txn(4'b1001, TIMEOUT + 1, 2, 0);

    // stray done in IDLE
    @(posedge clk); #1;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    @(negedge clk);
    chk("stray_idle_busy", bus.busy, 0);
    chk("stray_idle_rsp", bus.rsp_valid, 0);
    chk("stray_idle_result", bus.rsp_result, last_res_m);

    // backpressure with requests and a stray done during RESP
    rand_ops();
    fork
      do_txn(4'b0010, 2, 11, 0);
      begin
        for (int n = 0; n < 40; n++) begin
          if (bus.rsp_valid != '0) break;
          @(negedge clk);
        end
        @(posedge clk); #1;
        vld = '1;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vld = '0;
      end
    join

    // reset while WAITing on requester 2, then pointer back to NREQ-1
    rand_ops();
    do_txn(4'b0010, 2, 0, 0);
    do_txn(4'b0100, 0, 0, 3);
    rand_ops();
    do_txn(4'b1111, 1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      rand_ops();
      sel = $urandom_range(0, 9);
      lat = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT + 1 : int'($urandom_range(1, TIMEOUT));
      do_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), lat, $urandom_range(0, 3), 0);
    end

    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("issue_queue_drained", iss_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Sequences a single shared multi-cycle ALU among NREQ independent requesters.
- Round-robin arbitration accepts one operation at a time and drives the ALU start/done handshake.
- Routes the result and flags back to the originating requester; a watchdog aborts hung ALU operations.
- Sits between the issue/execute front-ends and the ALU_Components datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width
- TIMEOUT, 64, max cycles in WAIT before abort (≥2)

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operation valid
- req_op  in  NREQ*OP_W  packed opcodes, requester i at [i*OP_W +: OP_W]
- req_a  in  NREQ*DATA_W  packed operand A
- req_b  in  NREQ*DATA_W  packed operand B
- req_ready  out  NREQ  one-hot accept strobe
- alu_start  out  1  one-cycle start pulse to ALU
- alu_op  out  OP_W  opcode to ALU
- alu_a  out  DATA_W  operand A to ALU
- alu_b  out  DATA_W  operand B to ALU
- alu_done  in  1  ALU completion pulse
- alu_result  in  DATA_W  ALU result, valid with alu_done
- alu_flags  in  4  {N,Z,C,V}, valid with alu_done
- rsp_valid  out  NREQ  one-hot response valid
- rsp_result  out  DATA_W  registered result
- rsp_flags  out  4  registered flags
- rsp_err  out  1  timeout abort indicator, valid with rsp_valid
- rsp_ack  in  NREQ  per-requester response acknowledge
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, n_rst=0): state=IDLE.
  - All outputs 0: req_ready, alu_start, alu_op/a/b, rsp_valid, rsp_result, rsp_flags, rsp_err, busy.
  - Timeout counter = 0.
  - RR pointer last = NREQ-1, so requester 0 has highest priority after reset.
- Reset mid-operation aborts the transaction silently; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - g = first i with req_valid[i]=1, searching last+1, last+2, … modulo NREQ.
  - req_ready is combinational: req_ready[g]=1 only in IDLE with some req_valid high; otherwise all 0.
  - On transfer (req_valid[g] & req_ready[g]), capture op/a/b of g into holding regs, record g, go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE: alu_start=1 for exactly one cycle; reset the timeout counter; go to WAIT.
- alu_op/a/b are driven from the holding regs and stay stable from ISSUE through the end of WAIT.
- alu_op/a/b = 0 in IDLE and RESP.
- WAIT:
  - alu_done=1: register alu_result/alu_flags into rsp_result/rsp_flags, rsp_err=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without done, set rsp_result=0, rsp_flags=0, rsp_err=1, go to RESP.
  - alu_done in the same cycle as the timeout terminal count: done wins, rsp_err=0.
- alu_done is ignored in IDLE, ISSUE and RESP (no state or data change).
- RESP:
  - rsp_valid[g]=1; rsp_result/flags/err held stable until rsp_ack[g]=1.
  - On ack: clear rsp_valid and rsp_err, set last=g, go to IDLE.
  - rsp_ack on other bits is ignored.
- last is updated only on response completion, so a requester's re-request in the following cycle loses to any other pending requester.
- Fairness: with all NREQ continuously requesting, grants cycle 0,1,…,NREQ-1,0,…
- Timing with ALU latency L (done L cycles after start, L≥1) and immediate ack:
  - accept at cycle 0, alu_start at cycle 1, done at cycle 1+L;
  - rsp_valid visible from cycle 2+L;
  - next accept possible at cycle 3+L.
- Throughput: exactly one outstanding ALU operation; never assert alu_start while in WAIT or RESP.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset, single request: after reset, req_valid=0001, op=ADD, a=5, b=7; ALU model done 3 cycles after start returning 12, flags 0000.
  - Required: req_ready=0001 at cycle 0; alu_start at cycle 1 with a=5, b=7; rsp_valid=0001 at cycle 5, rsp_result=12; back in IDLE one cycle after ack.
- Round-robin: req_valid=1111 held, ALU latency 1, immediate ack.
  - Required: grant order 0,1,2,3,0 over five transactions; each rsp_valid one-hot matches its grant.
- Priority after completion: requester 2 served; then req_valid=0101.
  - Required: requester 0 is granted next (search starts at 3, wraps to 0).
- Timeout: alu_done never asserted, TIMEOUT=8.
  - Required: rsp_valid and rsp_err=1 with rsp_result=0 in the cycle after the 8th WAIT cycle; subsequent request proceeds normally.
- Stray and boundary done:
  - alu_done pulsed in IDLE and in RESP: no state or output change.
  - alu_done coinciding with the terminal timeout count: rsp_err=0 and the result is captured.
- Backpressure and reset: rsp_ack held 0 for 10 cycles.
  - Required: rsp_valid, result and flags stable; req_ready stays 0 for all requesters.
  - n_rst pulsed during WAIT: all outputs 0 immediately, pointer back to NREQ-1, no response.
